// File: rtl/peripheral_responder_apb4_pkg.sv
// Shared types and defaults for the APB4 responder model and its register bank.
package peripheral_apb4_responder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_PADDR_SIZE  = 4;
  localparam int DEF_PDATA_SIZE  = 8;
  localparam int DEF_NUM_REGS    = 12;
  localparam int DEF_RESET_VALUE = 0;
  localparam int DEF_CNT_SIZE    = 16;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/peripheral_regbank_apb4.sv
// Byte-strobed register bank with one write port and one asynchronous read port.
module peripheral_regbank_apb4
  import peripheral_apb4_responder_pkg::*;
#(
  parameter int                      PDATA_SIZE  = DEF_PDATA_SIZE,
  parameter int                      NUM_REGS    = DEF_NUM_REGS,
  parameter int                      IDX_W       = 4,
  parameter logic [PDATA_SIZE-1:0]   RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [IDX_W-1:0]                  wr_idx,
  input  logic [lane_count(PDATA_SIZE)-1:0] wr_strb,
  input  logic [PDATA_SIZE-1:0]             wr_data,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic [PDATA_SIZE-1:0]             rd_data
);

  localparam int LANES = lane_count(PDATA_SIZE);

  logic [PDATA_SIZE-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VALUE;
    end else if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Out-of-range indices read as zero; the responder flags them as errors anyway.
  assign rd_data = (int'(rd_idx) < NUM_REGS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/peripheral_responder_apb4.sv
// APB4 completer model: register bank, programmable wait states, error injection,
// protocol checker and saturating transfer statistics.
module peripheral_responder_apb4
  import peripheral_apb4_responder_pkg::*;
#(
  parameter int PADDR_SIZE  = DEF_PADDR_SIZE,
  parameter int PDATA_SIZE  = DEF_PDATA_SIZE,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int RESET_VALUE = DEF_RESET_VALUE,
  parameter int CNT_SIZE    = DEF_CNT_SIZE
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              PSEL,
  input  logic                              PENABLE,
  input  logic [PADDR_SIZE-1:0]             PADDR,
  input  logic                              PWRITE,
  input  logic [lane_count(PDATA_SIZE)-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]             PWDATA,
  output logic [PDATA_SIZE-1:0]             PRDATA,
  output logic                              PREADY,
  output logic                              PSLVERR,
  input  logic [3:0]                        wait_i,
  input  logic                              err_inject_i,
  output logic                              proto_err_o,
  output logic [CNT_SIZE-1:0]               wr_cnt_o,
  output logic [CNT_SIZE-1:0]               rd_cnt_o,
  output logic [CNT_SIZE-1:0]               err_cnt_o
);

  localparam int LANES = lane_count(PDATA_SIZE);
  localparam int OFS   = $clog2(LANES);
  localparam int IDX_W = PADDR_SIZE - OFS;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic [PADDR_SIZE-1:0] addr_q;
  logic                  write_q;
  logic [LANES-1:0]      strb_q;
  logic [PDATA_SIZE-1:0] wdata_q;
  logic                  err_q;
  logic [3:0]            wcnt_q;

  logic                  setup_fire, wait_tick, complete, abort;
  logic [IDX_W-1:0]      paddr_idx, addr_idx, rd_idx;
  logic [PDATA_SIZE-1:0] rd_data;
  logic                  setup_err, violation;

  assign paddr_idx = PADDR[PADDR_SIZE-1:OFS];
  assign addr_idx  = addr_q[PADDR_SIZE-1:OFS];
  assign rd_idx    = (state_q == IDLE) ? paddr_idx : addr_idx;
  assign setup_err = err_inject_i | (int'(paddr_idx) >= NUM_REGS);

  always_comb begin
    state_d    = state_q;
    setup_fire = 1'b0;
    wait_tick  = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup_fire = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (PENABLE && PREADY) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (PENABLE) begin
          wait_tick = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any field moving after setup, a stray PENABLE, or a strobed read is a violation.
  always_comb begin
    violation = 1'b0;
    if (state_q == IDLE && PENABLE) violation = 1'b1;
    if (setup_fire && !PWRITE && (PSTRB != '0)) violation = 1'b1;
    if (abort) violation = 1'b1;
    if (state_q == ACCESS && PSEL &&
        (!PENABLE || PADDR != addr_q || PWRITE != write_q ||
         PSTRB != strb_q || PWDATA != wdata_q)) violation = 1'b1;
  end

  // Transfer attributes are captured at the setup edge; no reset needed.
  always_ff @(posedge PCLK) begin
    if (setup_fire) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      strb_q  <= PSTRB;
      wdata_q <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      PRDATA      <= '0;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      proto_err_o <= 1'b0;
      wr_cnt_o    <= '0;
      rd_cnt_o    <= '0;
      err_cnt_o   <= '0;
    end else begin
      state_q <= state_d;
      if (violation) proto_err_o <= 1'b1;
      if (setup_fire) begin
        wcnt_q <= wait_i;
        err_q  <= setup_err;
        PREADY <= (wait_i == 4'd0);
        if (wait_i == 4'd0) begin
          PSLVERR <= setup_err;
          PRDATA  <= (!setup_err && !PWRITE) ? rd_data : '0;
        end
      end else if (wait_tick) begin
        wcnt_q <= wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          PREADY  <= 1'b1;
          PSLVERR <= err_q;
          PRDATA  <= (!err_q && !write_q) ? rd_data : '0;
        end
      end else if (complete || abort) begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
        PRDATA  <= '0;
        if (complete) begin
          if (err_q)        err_cnt_o <= sat_inc(err_cnt_o);
          else if (write_q) wr_cnt_o  <= sat_inc(wr_cnt_o);
          else              rd_cnt_o  <= sat_inc(rd_cnt_o);
        end
      end
    end
  end

  peripheral_regbank_apb4 #(
    .PDATA_SIZE  (PDATA_SIZE),
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W),
    .RESET_VALUE (PDATA_SIZE'(RESET_VALUE))
  ) u_regbank (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we      (complete && write_q && !err_q),
    .wr_idx  (addr_idx),
    .wr_strb (strb_q),
    .wr_data (wdata_q),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule
